// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer for a variable-latency imem: one outstanding request,
// holds the returned instruction for IF/ID, and squashes fetches on EX redirects.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        id_ready,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic        req_valid_q, req_valid_d;
  logic        instr_valid_q, instr_valid_d;
  logic        busy_q, busy_d;
  logic [31:0] redir_tgt;

  assign redir_tgt = redirect_pc & ~32'h0000_0003;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    redir_pend_d = redir_pend_q;
    instr_d      = instr_q;
    fault_d      = fetch_fault_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redir_tgt;
      end

      // The request address must not move before the handshake, so a redirect
      // seen here is parked in pend_pc and the eventual response is dropped.
      S_REQ: begin
        if (imem_req_ready) begin
          if (redirect_valid) begin
            pend_pc_d    = redir_tgt;
            redir_pend_d = 1'b1;
            state_d      = S_DROP;
          end else if (redir_pend_q) begin
            state_d = S_DROP;
          end else begin
            state_d = S_WAIT;
          end
        end else if (redirect_valid) begin
          pend_pc_d    = redir_tgt;
          redir_pend_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            pc_d    = redir_tgt;
            state_d = S_REQ;
          end else begin
            instr_d = imem_resp_err ? NOP_INSTR : imem_resp_data;
            fault_d = imem_resp_err;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          pend_pc_d    = redir_tgt;
          redir_pend_d = 1'b1;
          state_d      = S_DROP;
        end
      end

      S_DROP: begin
        if (imem_resp_valid) begin
          pc_d         = redirect_valid ? redir_tgt : pend_pc_q;
          redir_pend_d = 1'b0;
          state_d      = S_REQ;
        end else if (redirect_valid) begin
          pend_pc_d = redir_tgt;
        end
      end

      // A redirect squashes the held instruction even if IF/ID is ready.
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_d    = pred_taken ? pred_target : pc_q + 32'd4;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase

    req_valid_d   = (state_d == S_REQ);
    instr_valid_d = (state_d == S_HOLD);
    busy_d        = (state_d == S_WAIT) || (state_d == S_DROP);
    fetch_fault_d = (state_d == S_HOLD) && fault_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= 32'h0;
      redir_pend_q  <= 1'b0;
      instr_q       <= 32'h0;
      fetch_fault_q <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      redir_pend_q  <= redir_pend_d;
      instr_q       <= instr_d;
      fetch_fault_q <= fetch_fault_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign pc_if          = pc_q;
  assign instr_if       = instr_q;
  assign instr_valid    = instr_valid_q;
  assign fetch_fault    = fetch_fault_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus a randomized run
// checked against a fetch-stream model (next PC from redirects, predictions, PC+4).
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_ready;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic        instr_valid;
  logic        fetch_fault;
  logic        busy;

  int tests;
  int fails;

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .id_ready(id_ready),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .pc_if(pc_if), .instr_if(instr_if), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    pred_taken      = 1'b0;
    pred_target     = 32'h0;
    id_ready        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
  endtask

  task automatic do_handshake();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
  endtask

  task automatic do_resp(input logic [31:0] data, input logic err);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_valid got %b want 0", imem_req_valid); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_instr_valid got %b want 0", instr_valid); end
    tests++; if (fetch_fault !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_flags got fault=%b busy=%b want 0 0", fetch_fault, busy); end
    tests++; if (pc_if !== 32'h0) begin fails++; $display("[TB] FAIL reset_pc got %h want 00000000", pc_if); end
    tests++; if (instr_if !== 32'h0) begin fails++; $display("[TB] FAIL reset_instr got %h want 00000000", instr_if); end
    step();
    step();
    rst = 1'b1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_req_valid got %b want 0", imem_req_valid); end
    step();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("[TB] FAIL first_req got v=%b a=%h want 1 00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 32'(k * 4);
      tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin fails++; $display("[TB] FAIL seq_req got v=%b a=%h want 1 %h", imem_req_valid, imem_req_addr, a); end
      do_handshake();
      tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL seq_busy got %b want 1", busy); end
      do_resp(mem_word(a), 1'b0);
      tests++; if (instr_valid !== 1'b1 || pc_if !== a) begin fails++; $display("[TB] FAIL seq_hold got v=%b pc=%h want 1 %h", instr_valid, pc_if, a); end
      tests++; if (instr_if !== mem_word(a) || fetch_fault !== 1'b0) begin fails++; $display("[TB] FAIL seq_data got %h f=%b want %h 0", instr_if, fetch_fault, mem_word(a)); end
      step();
    end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_handshake();
    do_resp(mem_word(32'hC), 1'b0);
    for (int k = 0; k < 5; k++) begin
      tests++; if (instr_valid !== 1'b1 || pc_if !== 32'hC || instr_if !== mem_word(32'hC)) begin fails++; $display("[TB] FAIL bp_hold got v=%b pc=%h i=%h want 1 0000000c %h", instr_valid, pc_if, instr_if, mem_word(32'hC)); end
      tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_no_req got %b want 0", imem_req_valid); end
      step();
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin fails++; $display("[TB] FAIL bp_next got v=%b a=%h want 1 00000010", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    do_handshake();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    tests++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("[TB] FAIL rw_drop got busy=%b v=%b want 1 0", busy, instr_valid); end
    step();
    do_resp(mem_word(32'h10), 1'b0);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("[TB] FAIL rw_old_valid got %b want 0", instr_valid); end
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin fails++; $display("[TB] FAIL rw_req got v=%b a=%h want 1 00000100", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_same_cycle();
    do_handshake();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    do_resp(mem_word(32'h100), 1'b0);
    redirect_valid = 1'b0;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin fails++; $display("[TB] FAIL rs_req got v=%b a=%h want 1 00000200", imem_req_valid, imem_req_addr); end
    tests++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL rs_flags got v=%b busy=%b want 0 0", instr_valid, busy); end
    do_handshake();
    do_resp(mem_word(32'h200), 1'b0);
    tests++; if (instr_valid !== 1'b1 || pc_if !== 32'h200 || instr_if !== mem_word(32'h200)) begin fails++; $display("[TB] FAIL rs_hold got v=%b pc=%h i=%h want 1 00000200 %h", instr_valid, pc_if, instr_if, mem_word(32'h200)); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    id_ready       = 1'b1;
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 || instr_valid !== 1'b0) begin fails++; $display("[TB] FAIL hold_squash got v=%b a=%h iv=%b want 1 00000040 0", imem_req_valid, imem_req_addr, instr_valid); end
  endtask

  task automatic test_redirect_stalled_req();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h280;
    step();
    redirect_pc    = 32'h303;
    step();
    redirect_valid = 1'b0;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin fails++; $display("[TB] FAIL sr_hold1 got v=%b a=%h want 1 00000040", imem_req_valid, imem_req_addr); end
    step();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin fails++; $display("[TB] FAIL sr_hold2 got v=%b a=%h want 1 00000040", imem_req_valid, imem_req_addr); end
    do_handshake();
    tests++; if (busy !== 1'b1 || imem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL sr_drop got busy=%b v=%b want 1 0", busy, imem_req_valid); end
    do_resp(mem_word(32'h40), 1'b0);
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || instr_valid !== 1'b0) begin fails++; $display("[TB] FAIL sr_req got v=%b a=%h iv=%b want 1 00000300 0", imem_req_valid, imem_req_addr, instr_valid); end
  endtask

  task automatic test_btb_error();
    do_handshake();
    do_resp(mem_word(32'h300), 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    do_handshake();
    do_resp(mem_word(32'h10), 1'b0);
    tests++; if (instr_valid !== 1'b1 || pc_if !== 32'h10) begin fails++; $display("[TB] FAIL btb_hold got v=%b pc=%h want 1 00000010", instr_valid, pc_if); end
    pred_taken  = 1'b1;
    pred_target = 32'h80;
    id_ready    = 1'b1;
    step();
    pred_taken  = 1'b0;
    id_ready    = 1'b0;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin fails++; $display("[TB] FAIL btb_req got v=%b a=%h want 1 00000080", imem_req_valid, imem_req_addr); end
    do_handshake();
    do_resp(32'hDEAD_BEEF, 1'b1);
    tests++; if (instr_valid !== 1'b1 || instr_if !== NOP || fetch_fault !== 1'b1) begin fails++; $display("[TB] FAIL err_hold got v=%b i=%h f=%b want 1 %h 1", instr_valid, instr_if, fetch_fault, NOP); end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    tests++; if (imem_req_addr !== 32'h84 || fetch_fault !== 1'b0) begin fails++; $display("[TB] FAIL err_next got a=%h f=%b want 00000084 0", imem_req_addr, fetch_fault); end
  endtask

  task automatic test_wrap();
    do_handshake();
    do_resp(mem_word(32'h84), 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    tests++; if (imem_req_addr !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL wrap_redir got %h want fffffffc", imem_req_addr); end
    do_handshake();
    do_resp(mem_word(32'hFFFF_FFFC), 1'b0);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("[TB] FAIL wrap_pc4 got v=%b a=%h want 1 00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_midflight();
    do_handshake();
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy got %b want 1", busy); end
    #2 rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || pc_if !== 32'h0) begin fails++; $display("[TB] FAIL mid_reset got busy=%b v=%b iv=%b pc=%h want 0 0 0 00000000", busy, imem_req_valid, instr_valid, pc_if); end
    step();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h503;
    step();
    redirect_valid = 1'b0;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h500) begin fails++; $display("[TB] FAIL idle_redir got v=%b a=%h want 1 00000500", imem_req_valid, imem_req_addr); end
  endtask

  // Randomized run: the memory responder and the expected fetch stream are modelled
  // at transaction level; every delivered instruction is checked against both.
  task automatic test_random();
    logic [31:0] exp_pc, out_addr, last_addr, last_data, prev_addr;
    logic        outstanding, last_err, prev_stall;
    int          lat, deliveries, idle_cycles;
    clear_inputs();
    rst = 1'b0;
    #1;
    step();
    rst = 1'b1;
    exp_pc = 32'h0; outstanding = 1'b0; lat = 0; deliveries = 0; idle_cycles = 0;
    last_addr = 32'h0; last_data = 32'h0; last_err = 1'b0; out_addr = 32'h0;
    prev_stall = 1'b0; prev_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tests++; if (busy !== outstanding) begin fails++; $display("[TB] FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, outstanding); end
      if (prev_stall) begin
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin fails++; $display("[TB] FAIL rnd_stable cyc %0d got v=%b a=%h want 1 %h", cyc, imem_req_valid, imem_req_addr, prev_addr); end
      end
      imem_req_ready = ($urandom % 3) != 0;
      id_ready       = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = $urandom;
      pred_taken     = $urandom % 2;
      pred_target    = $urandom & ~32'h3;
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      imem_resp_data  = $urandom;
      if (outstanding) begin
        if (lat == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(out_addr);
          imem_resp_err   = ($urandom % 5) == 0;
        end else begin
          lat--;
        end
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
        outstanding = 1'b1;
        out_addr    = imem_req_addr;
        lat         = $urandom_range(0, 3);
      end else if (imem_resp_valid) begin
        outstanding = 1'b0;
        last_addr   = out_addr;
        last_data   = imem_resp_data;
        last_err    = imem_resp_err;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && id_ready) begin
        tests++; if (pc_if !== exp_pc || pc_if !== last_addr) begin fails++; $display("[TB] FAIL rnd_pc cyc %0d got %h want %h (fetched %h)", cyc, pc_if, exp_pc, last_addr); end
        tests++; if (instr_if !== (last_err ? NOP : last_data) || fetch_fault !== last_err) begin fails++; $display("[TB] FAIL rnd_data cyc %0d got %h f=%b want %h f=%b", cyc, instr_if, fetch_fault, last_err ? NOP : last_data, last_err); end
        exp_pc = pred_taken ? pred_target : pc_if + 32'd4;
        deliveries++;
        idle_cycles = 0;
      end
      idle_cycles++;
      if (idle_cycles > 150) begin
        tests++; fails++;
        $display("[TB] FAIL rnd_timeout cyc %0d no delivery in 150 cycles", cyc);
        break;
      end
      step();
    end
    clear_inputs();
    tests++; if (deliveries < 100) begin fails++; $display("[TB] FAIL rnd_progress got %0d deliveries want >= 100", deliveries); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_stalled_req();
    test_btb_error();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequences instruction fetch from an instruction memory with variable latency, using a valid/ready request and response-valid interface.
- Owns the fetch PC. Issues one outstanding request at a time, holds the returned instruction for IF/ID until it is accepted, then picks the next PC from the BTB prediction or PC+4.
- Handles EX redirects by discarding in-flight or held fetches.
- Sits between the EX redirect/BTB logic and the IF/ID register. It replaces free-running fetch when imem is not single-cycle.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented on a fetch error.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- redirect_valid, input, 1, EX redirect request (modify_pc_ex).
- redirect_pc, input, 32, redirect target; bits [1:0] are ignored and forced to 0.
- pred_taken, input, 1, BTB predicts taken for the current pc_if.
- pred_target, input, 32, BTB target for the current pc_if.
- id_ready, input, 1, IF/ID can accept an instruction this cycle.
- imem_req_ready, input, 1, memory accepts the request.
- imem_resp_valid, input, 1, response is present this cycle.
- imem_resp_data, input, 32, response instruction.
- imem_resp_err, input, 1, response is an access fault; qualified by imem_resp_valid.
- imem_req_valid, output, 1, request valid.
- imem_req_addr, output, 32, request address; equals pc_if.
- pc_if, output, 32, PC of the current fetch.
- instr_if, output, 32, held instruction.
- instr_valid, output, 1, instr_if/pc_if are valid for IF/ID.
- fetch_fault, output, 1, held instruction came from an error response; qualified by instr_valid.
- busy, output, 1, a request is outstanding (state is WAIT or DROP).

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, pc = RESET_PC, pend_pc = 0, redir_pend = 0, instr_if = 0.
  - All 1-bit outputs = 0.
- FSM states: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE:
  - Goes to REQ on the first clock after rst deasserts.
  - A redirect in IDLE loads pc = redirect_pc.
- REQ:
  - imem_req_valid = 1 and imem_req_addr = pc.
  - addr stays stable until the handshake (valid & ready).
  - Handshake with no redirect and no pending redirect -> WAIT.
  - redirect_valid with !imem_req_ready: stay in REQ, latch pend_pc = redirect_pc, set redir_pend, keep addr unchanged.
  - Handshake while redirect_valid or redir_pend -> DROP. pend_pc is taken from redirect_valid if it is asserted this cycle, else from the latched value.
  - A later redirect overwrites pend_pc; the newest redirect wins.
- WAIT:
  - On resp_valid: capture instr_if = err ? NOP_INSTR : resp_data, set fetch_fault = err, go to HOLD.
  - redirect_valid without resp_valid: pend_pc = redirect_pc, go to DROP.
  - redirect_valid together with resp_valid: discard the response, pc = redirect_pc, go to REQ. The redirect has priority.
- DROP:
  - Waits for resp_valid and discards the data.
  - Then sets pc = pend_pc, clears redir_pend, and goes to REQ.
  - A redirect in DROP updates pend_pc.
  - A redirect and resp_valid in the same cycle use the new redirect_pc.
- HOLD:
  - instr_valid = 1.
  - instr_valid & id_ready with no redirect: pc = pred_taken ? pred_target : pc + 4, go to REQ.
  - redirect_valid, with or without id_ready: the held instruction is squashed (it is not counted as transferred), pc = redirect_pc, go to REQ.
- instr_valid and fetch_fault are 1 only in HOLD.
- pc + 4 wraps modulo 2^32.
- At most one request is outstanding, so there is no response reordering.
- Reset mid-transaction returns to IDLE. The memory is reset by the same rst, so no stale response is expected.
- Throughput is one instruction per 3 cycles minimum with zero-wait memory (REQ, WAIT, HOLD).

Test Plan:
- Reset and sequential fetch: rst low then high, ready = 1, responses 1 cycle after request, id_ready = 1. Required: req addrs 0x0, 0x4, 0x8; instr_valid pulses carry those PCs and data.
- Backpressure: id_ready = 0 for 5 cycles in HOLD. Required: instr_if, pc_if and instr_valid stay stable; no new request until id_ready = 1.
- Redirect while waiting: redirect_pc = 0x100 in WAIT, response arrives 2 cycles later. Required: response dropped, next request addr = 0x100, no instr_valid for the old PC.
- Redirect and response in the same cycle in WAIT: redirect_pc = 0x200. Required: next cycle REQ with addr 0x200; old data never presented.
- Redirect during stalled REQ: imem_req_ready = 0, addr 0x40, redirect to 0x300, ready rises 3 cycles later. Required: addr held at 0x40 until accept, DROP, then request 0x300.
- BTB taken and error: pc 0x10 HOLD with pred_taken = 1, pred_target = 0x80. Required: next request 0x80. Then resp_err = 1 -> instr_if = 0x00000013 with fetch_fault = 1.
